// File: rtl/move_sequence_writer_if.sv
// Host/dmem-facing signal bundle for move_sequence_writer.
// The master side is the host (it drives move codes and the commit/clear
// controls); the slave side is the writer itself.
interface move_sequence_writer_if;
    logic [3:0]  move_in;
    logic        move_valid;
    logic        move_ready;
    logic        commit;
    logic        clear;
    logic        dmem_wren;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_data;
    logic [5:0]  seq_len;
    logic        seq_ready;
    logic        overflow;
    logic        bad_code;

    modport master (
        output move_in, move_valid, commit, clear,
        input  move_ready, dmem_wren, dmem_addr, dmem_data,
               seq_len, seq_ready, overflow, bad_code
    );

    modport slave (
        input  move_in, move_valid, commit, clear,
        output move_ready, dmem_wren, dmem_addr, dmem_data,
               seq_len, seq_ready, overflow, bad_code
    );
endinterface

// File: rtl/move_sequence_writer.sv
// Producer side of the move-code memory: buffers host move codes in a small
// FIFO, streams them into dmem from BASE_ADDR one per cycle, then appends the
// terminator and flags the sequence as ready for the servo sequencer.
// FIFO_DEPTH must be a power of two and at least 2 (pointers wrap naturally).
module move_sequence_writer #(
    parameter logic [31:0] BASE_ADDR  = 32'd25,
    parameter int          MAX_MOVES  = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [3:0]  TERM_CODE  = 4'hF
) (
    input  logic                  clk,
    input  logic                  rst,
    move_sequence_writer_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_TERM, S_DONE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [3:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_commit_pending;
    logic [5:0]    r_seq_len;
    logic          r_seq_ready;
    logic          r_overflow;
    logic          r_bad_code;
    logic          r_dmem_wren;
    logic [31:0]   r_dmem_addr;
    logic [3:0]    r_dmem_data;

    logic          w_active;
    logic          w_full;
    logic          w_cap_ok;
    logic          w_ready;
    logic          w_cap_block;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_term;
    logic          w_pending_nxt;
    logic [CW-1:0] w_count_nxt;

    // Handshake qualification, drain/terminator decisions and next state.
    // seq_len + occupancy is the number of moves claimed so far, so the
    // capacity check stays correct while entries are still in flight.
    always_comb begin
        w_state_nxt   = r_state;
        w_active      = (r_state == S_IDLE) || (r_state == S_WRITE);
        w_full        = (r_count == CW'(FIFO_DEPTH));
        w_cap_ok      = ({1'b0, r_seq_len} + 7'(r_count)) < 7'(MAX_MOVES);
        w_ready       = w_active && !w_full && !r_commit_pending && w_cap_ok && !bus.clear;
        w_cap_block   = w_active && !w_full && !r_commit_pending && !w_cap_ok && !bus.clear;
        w_accept      = bus.move_valid && w_ready;
        w_push        = w_accept && (bus.move_in != TERM_CODE);
        w_pop         = w_active && (r_count != '0) && !bus.clear;
        w_term        = w_active && (r_count == '0) && r_commit_pending && !bus.clear;
        w_count_nxt   = r_count + CW'(w_push) - CW'(w_pop);
        w_pending_nxt = r_commit_pending || (w_active && bus.commit);

        if (bus.clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_WRITE: begin
                    if (w_term)
                        w_state_nxt = S_TERM;
                    else if ((w_count_nxt != '0) || w_pending_nxt)
                        w_state_nxt = S_WRITE;
                    else
                        w_state_nxt = S_IDLE;
                end
                S_TERM:  w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_DONE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wptr] <= bus.move_in;
    end

    // FIFO pointers, dmem write port, length counter and status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr           <= '0;
            r_rptr           <= '0;
            r_count          <= '0;
            r_commit_pending <= 1'b0;
            r_seq_len        <= '0;
            r_seq_ready      <= 1'b0;
            r_overflow       <= 1'b0;
            r_bad_code       <= 1'b0;
            r_dmem_wren      <= 1'b0;
            r_dmem_addr      <= BASE_ADDR;
            r_dmem_data      <= '0;
        end else if (bus.clear) begin
            // dmem_addr/data keep their last values; old words are simply orphaned.
            r_wptr           <= '0;
            r_rptr           <= '0;
            r_count          <= '0;
            r_commit_pending <= 1'b0;
            r_seq_len        <= '0;
            r_seq_ready      <= 1'b0;
            r_overflow       <= 1'b0;
            r_bad_code       <= 1'b0;
            r_dmem_wren      <= 1'b0;
        end else begin
            r_dmem_wren <= 1'b0;
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr      <= r_rptr + 1'b1;
                r_dmem_wren <= 1'b1;
                r_dmem_addr <= BASE_ADDR + 32'(r_seq_len);
                r_dmem_data <= r_fifo[r_rptr];
                r_seq_len   <= r_seq_len + 6'd1;
            end else if (w_term) begin
                r_dmem_wren <= 1'b1;
                r_dmem_addr <= BASE_ADDR + 32'(r_seq_len);
                r_dmem_data <= TERM_CODE;
            end
            r_count <= w_count_nxt;
            if (w_active && bus.commit)
                r_commit_pending <= 1'b1;
            else if (r_state == S_TERM)
                r_commit_pending <= 1'b0;
            if (r_state == S_TERM)
                r_seq_ready <= 1'b1;
            if (bus.move_valid && w_cap_block)
                r_overflow <= 1'b1;
            if (w_accept && (bus.move_in == TERM_CODE))
                r_bad_code <= 1'b1;
        end
    end

    assign bus.move_ready = w_ready;
    assign bus.dmem_wren  = r_dmem_wren;
    assign bus.dmem_addr  = r_dmem_addr;
    assign bus.dmem_data  = r_dmem_data;
    assign bus.seq_len    = r_seq_len;
    assign bus.seq_ready  = r_seq_ready;
    assign bus.overflow   = r_overflow;
    assign bus.bad_code   = r_bad_code;
endmodule

// File: tb/tb_move_sequence_writer.sv
// Bench for move_sequence_writer: directed scenarios plus random traffic.
// The driver keeps a sequence-level model (list of accepted moves, count of
// moves written, commit/terminator flags) and pushes each expected dmem write
// into a scoreboard queue; a negedge monitor pops and compares.
module tb_move_sequence_writer;
    localparam logic [31:0] BASE = 32'd25;
    localparam int          MAXM = 32;
    localparam logic [3:0]  TERM = 4'hF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    move_sequence_writer_if bus();

    move_sequence_writer #(
        .BASE_ADDR(BASE), .MAX_MOVES(MAXM), .FIFO_DEPTH(4), .TERM_CODE(TERM)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;

    // Reference model state
    logic [35:0] exp_q[$];   // {addr, data} of writes due this cycle
    logic [3:0]  m_pend[$];  // accepted moves not yet in dmem
    int          m_len;      // moves written to dmem
    int          m_pushed;   // moves accepted into the sequence
    bit          m_comm, m_termd, m_sready, m_ovf, m_bad;
    logic [31:0] m_addr;
    logic [3:0]  m_data;

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic mclear();
        m_pend.delete();
        m_len = 0; m_pushed = 0;
        m_comm = 0; m_termd = 0; m_sready = 0; m_ovf = 0; m_bad = 0;
    endtask

    task automatic mreset();
        mclear();
        exp_q.delete();
        m_addr = BASE;
        m_data = 4'h0;
    endtask

    task automatic push_exp(input logic [3:0] d);
        m_addr = BASE + 32'(m_len);
        m_data = d;
        exp_q.push_back({m_addr, m_data});
    endtask

    // One clock of stimulus with model update at the active edge.
    task automatic step(input bit v, input logic [3:0] c, input bit cm, input bit cl, input bit rs);
        bit mr, capb, old_t;
        @(negedge clk);
        #1;
        rst = rs; bus.move_valid = v; bus.move_in = c; bus.commit = cm; bus.clear = cl;
        mr   = !cl && !m_comm && (m_pushed < MAXM);
        capb = !cl && !m_comm && (m_pushed >= MAXM);
        #1;
        if (rs && mon_en) chk("move_ready", {35'd0, bus.move_ready}, {35'd0, mr});
        @(posedge clk);
        if (!rs) mreset();
        else if (cl) mclear();
        else begin
            old_t = m_termd;
            if (m_pend.size() != 0) begin
                push_exp(m_pend.pop_front());
                m_len++;
            end else if (m_comm && !m_termd) begin
                push_exp(TERM);
                m_termd = 1;
            end
            if (old_t) m_sready = 1;
            if (v && mr) begin
                if (c == TERM) m_bad = 1;
                else begin m_pend.push_back(c); m_pushed++; end
            end
            if (v && capb) m_ovf = 1;
            if (cm) m_comm = 1;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 4'h0, 0, 0, 1);
    endtask

    // Monitor: compare registered outputs against the model each cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("dmem_wren", {35'd0, bus.dmem_wren}, {35'd0, exp_q.size() != 0});
            if (bus.dmem_wren && exp_q.size() != 0)
                chk("dmem_write", {bus.dmem_addr, bus.dmem_data}, exp_q.pop_front());
            else begin
                exp_q.delete();
                if (!bus.dmem_wren)
                    chk("dmem_hold", {bus.dmem_addr, bus.dmem_data}, {m_addr, m_data});
            end
            chk("seq_len",   {30'd0, bus.seq_len},   {30'd0, 6'(m_len)});
            chk("seq_ready", {35'd0, bus.seq_ready}, {35'd0, m_sready});
            chk("overflow",  {35'd0, bus.overflow},  {35'd0, m_ovf});
            chk("bad_code",  {35'd0, bus.bad_code},  {35'd0, m_bad});
        end
    end

    initial begin
        bus.move_valid = 1'b0; bus.move_in = 4'h0; bus.commit = 1'b0; bus.clear = 1'b0;
        mreset();
        step(0, 4'h0, 0, 0, 0);
        mon_en = 1'b1;
        step(0, 4'h0, 0, 0, 0);
        idle(1);

        // Back-to-back 0..3 then commit
        for (int i = 0; i < 4; i++) step(1, 4'(i), 0, 0, 1);
        step(0, 4'h0, 1, 0, 1);
        idle(4);
        step(0, 4'h0, 0, 1, 1);

        // Commit with no moves
        step(0, 4'h0, 1, 0, 1);
        idle(3);
        step(0, 4'h0, 0, 1, 1);

        // 34 offers against a 32-move capacity
        for (int i = 0; i < 34; i++) step(1, 4'(i % 15), 0, 0, 1);
        step(0, 4'h0, 1, 0, 1);
        idle(3);
        step(0, 4'h0, 0, 1, 1);

        // Reserved code between two legal moves
        step(1, 4'h2, 0, 0, 1);
        step(1, TERM, 0, 0, 1);
        step(1, 4'h5, 0, 0, 1);
        step(0, 4'h0, 1, 0, 1);
        idle(3);
        step(0, 4'h0, 0, 1, 1);

        // Commit alongside the 4th move, keep offering while committed
        for (int i = 0; i < 4; i++) step(1, 4'(i + 7), i == 3, 0, 1);
        for (int i = 0; i < 6; i++) step(1, 4'(i), 0, 0, 1);
        step(1, 4'h1, 0, 1, 1);

        // Clear mid-write, then reset in the middle of a later sequence
        step(1, 4'h9, 0, 0, 1);
        step(1, 4'hA, 0, 0, 1);
        step(1, 4'hB, 0, 1, 1);
        idle(3);
        step(1, 4'h3, 0, 0, 1);
        step(1, 4'h4, 0, 0, 1);
        step(1, 4'h6, 1, 0, 0);
        idle(3);

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            int len;
            len = $urandom_range(0, 40);
            for (int k = 0; k < len; k++)
                step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 30) == 0, $urandom_range(0, 60) == 0, 1);
            step(0, 4'h0, 1, 0, 1);
            idle($urandom_range(0, 4));
            step(0, 4'h0, 0, 1, 1);
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/move_sequence_writer.md
# move_sequence_writer

Producer side of the move-code memory that the servo sequencer consumes. Accepts 4-bit cube move codes from the host side (solver/UART front end) over a valid/ready handshake. Buffers them in a small FIFO and writes them one per cycle into dmem, starting at the move base address, then appends a terminator code. Raises `seq_ready` so the servo sequencer can be enabled to read the committed sequence back.

## Interface
Parameters:
- BASE_ADDR, 25, dmem word address of the first move code
- MAX_MOVES, 32, maximum move codes per sequence, excluding the terminator; ≤ 63
- FIFO_DEPTH, 4, input buffer entries; power of two
- TERM_CODE, 4'hF, end-of-sequence marker; reserved, never a legal move

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-low reset
- move_in  in  4  move code; legal values 0..14
- move_valid  in  1  move_in is valid this cycle
- move_ready  out  1  block can accept move_in this cycle
- commit  in  1  single-cycle pulse: the sequence is complete
- clear  in  1  single-cycle pulse: discard or release the sequence and return to IDLE
- dmem_wren  out  1  dmem write strobe, one cycle per word
- dmem_addr  out  32  dmem write address
- dmem_data  out  4  dmem write data
- seq_len  out  6  number of move codes written (terminator excluded)
- seq_ready  out  1  level; sequence plus terminator are in dmem
- overflow  out  1  sticky; a move was offered while the sequence was at capacity
- bad_code  out  1  sticky; a move with code TERM_CODE was offered and dropped

## Operation
- States: IDLE → WRITE → TERM → DONE.
  - IDLE: FIFO empty, no commit pending.
  - WRITE: FIFO non-empty or commit pending.
  - TERM: single cycle that writes the terminator.
  - DONE: holds until clear.
- Accept condition: move_valid & move_ready. The accepted code is pushed into the FIFO.
- move_ready = state ∈ {IDLE, WRITE} & !fifo_full & !commit_pending & (seq_len + occupancy < MAX_MOVES).
- A code equal to TERM_CODE is consumed by the handshake but not pushed, and sets bad_code.
- overflow is set in any cycle with move_valid=1 where move_ready=0 only because of the capacity term.
- Drain: every cycle the FIFO is non-empty in IDLE/WRITE, pop one entry and drive:
  - dmem_wren=1
  - dmem_addr = BASE_ADDR + seq_len
  - dmem_data = entry
  - then seq_len += 1
- A push and a pop in the same cycle are both performed; occupancy is unchanged.
- commit in IDLE/WRITE latches commit_pending. Once the FIFO is empty and commit_pending=1, enter TERM and write TERM_CODE at BASE_ADDR + seq_len. seq_len is not incremented.
- TERM → DONE: seq_ready=1 and commit_pending cleared.
- commit in TERM/DONE is ignored. commit with zero moves writes the terminator at BASE_ADDR, with seq_len=0.
- clear from any state, next cycle: state IDLE, FIFO flushed, commit_pending=0, seq_len=0, seq_ready=0, overflow=0, bad_code=0.
  - No dmem write occurs in that cycle.
  - Moves already written stay in dmem but are unreferenced.
- clear and commit in the same cycle: clear wins.
- clear and move_valid in the same cycle: the move is not accepted (move_ready is forced 0 that cycle).
- Address arithmetic is 32-bit unsigned. seq_len never exceeds MAX_MOVES, so there is no wrap-around.

## Timing
- Reset values (cycle after rst=0 sampled):
  - state IDLE, FIFO empty
  - dmem_wren=0, dmem_addr=BASE_ADDR, dmem_data=0
  - seq_len=0, seq_ready=0, overflow=0, bad_code=0
  - move_ready=1
- Reset has priority over clear, commit and the handshake, including in the middle of a write.
- All dmem_* outputs are registered. A code accepted at edge N is written to dmem at edge N+1 if the FIFO was empty; otherwise in FIFO order.
- Sustained throughput: 1 move/cycle.
- Terminator timing: written on the cycle after the last move write, or the cycle after commit if the FIFO is empty. seq_ready rises one cycle after the terminator write.
- dmem_addr/dmem_data hold their last values when dmem_wren=0.
- seq_len updates on the same edge as the corresponding write.

## Test plan
- Back-to-back moves 0,1,2,3 with valid held high, then commit → writes (25,0),(26,1),(27,2),(28,3),(29,F) on consecutive cycles; seq_len=4; seq_ready=1 one cycle after the (29,F) write.
- commit immediately after reset with no moves → single write (25,F); seq_len=0; seq_ready=1.
- Offer 34 moves with MAX_MOVES=32 → exactly 32 writes to addresses 25..56; move_ready low after the 32nd accept; overflow=1; after commit the terminator goes to address 57.
- move_in=F offered between moves 2 and 5 → only codes 2 and 5 are written, at 25 and 26; bad_code=1.
- Stall: hold dmem-side occupancy with 4 moves accepted while commit arrives with the FIFO non-empty → all 4 are written before the terminator; move_ready=0 from commit until clear.
- clear asserted mid-WRITE with 2 entries queued, then rst=0 during a later sequence → no further writes after clear; seq_len=0, seq_ready=0; after reset all outputs at reset values and move_ready=1.
